// File: rtl/l1_dcache_wb.sv
// Direct-mapped write-back L1 data cache with byte-merge stores, line flush,
// victim write-back and saturating hit/miss counters.
module l1_dcache_wb #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int LINE_W = 512,
    parameter int SETS   = 256,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic              cpu_we,
    input  logic              cpu_clf,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [1:0]        cpu_size,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_resp_valid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_resp_valid,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);
    localparam int OFFS_W = $clog2(LINE_W / 8);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFFS_W;
    localparam int BYTES  = DATA_W / 8;

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FILL_REQ, FILL_WAIT, RESPOND} state_t;

    state_t            state;
    logic              req_we, req_clf, refill;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic [DATA_W-1:0] req_wdata;

    logic [SETS-1:0]   valid, dirty;
    logic [TAG_W-1:0]  tags  [SETS];
    logic [LINE_W-1:0] lines [SETS];

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [OFFS_W-1:0] req_offs;
    logic [ADDR_W-1:0] fill_addr;
    logic [LINE_W-1:0] cur_line, merged;
    logic [DATA_W-1:0] load_val;
    logic              hit;

    assign req_tag   = req_addr[ADDR_W-1 -: TAG_W];
    assign req_idx   = req_addr[OFFS_W +: IDX_W];
    assign req_offs  = req_addr[OFFS_W-1:0] & ~(OFFS_W'((32'd1 << req_size) - 32'd1));
    assign fill_addr = {req_addr[ADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};
    assign cur_line  = lines[req_idx];
    assign hit       = valid[req_idx] && (tags[req_idx] == req_tag);

    assign cpu_req_ready = (state == IDLE) && !rst;

    always_comb begin
        merged   = cur_line;
        load_val = '0;
        for (int b = 0; b < BYTES; b++) begin
            if (b < (1 << req_size)) begin
                merged[(int'(req_offs) + b) * 8 +: 8]   = req_wdata[b * 8 +: 8];
                load_val[b * 8 +: 8] = cur_line[(int'(req_offs) + b) * 8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            valid          <= '0;
            dirty          <= '0;
            req_we         <= 1'b0;
            req_clf        <= 1'b0;
            refill         <= 1'b0;
            req_addr       <= '0;
            req_size       <= '0;
            req_wdata      <= '0;
            cpu_resp_valid <= 1'b0;
            cpu_rdata      <= '0;
            mem_req_valid  <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            hit_count      <= '0;
            miss_count     <= '0;
        end else begin
            cpu_resp_valid <= 1'b0;
            case (state)
                IDLE: if (cpu_req_valid) begin
                    req_we    <= cpu_we;
                    req_clf   <= cpu_clf;
                    req_addr  <= cpu_addr;
                    req_size  <= cpu_size;
                    req_wdata <= cpu_wdata;
                    refill    <= 1'b0;
                    state     <= LOOKUP;
                end
                LOOKUP: begin
                    if (req_clf) begin
                        cpu_rdata <= '0;
                        if (hit && dirty[req_idx]) begin
                            mem_req_valid <= 1'b1;
                            mem_we        <= 1'b1;
                            mem_addr      <= {tags[req_idx], req_idx, {OFFS_W{1'b0}}};
                            mem_wdata     <= cur_line;
                            state         <= WRITEBACK;
                        end else begin
                            if (hit) valid[req_idx] <= 1'b0;
                            cpu_resp_valid <= 1'b1;
                            state          <= RESPOND;
                        end
                    end else if (hit) begin
                        // A replay after a fill completes the access without counting a hit.
                        if (req_we) begin
                            dirty[req_idx] <= 1'b1;
                            cpu_rdata      <= '0;
                        end else begin
                            cpu_rdata <= load_val;
                        end
                        if (!refill && hit_count != '1) hit_count <= hit_count + 1'b1;
                        cpu_resp_valid <= 1'b1;
                        state          <= RESPOND;
                    end else begin
                        if (miss_count != '1) miss_count <= miss_count + 1'b1;
                        mem_req_valid <= 1'b1;
                        if (dirty[req_idx]) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= {tags[req_idx], req_idx, {OFFS_W{1'b0}}};
                            mem_wdata <= cur_line;
                            state     <= WRITEBACK;
                        end else begin
                            mem_we   <= 1'b0;
                            mem_addr <= fill_addr;
                            state    <= FILL_REQ;
                        end
                    end
                end
                WRITEBACK: if (mem_req_ready) begin
                    dirty[req_idx] <= 1'b0;
                    mem_we         <= 1'b0;
                    if (req_clf) begin
                        valid[req_idx] <= 1'b0;
                        mem_req_valid  <= 1'b0;
                        cpu_resp_valid <= 1'b1;
                        state          <= RESPOND;
                    end else begin
                        mem_addr <= fill_addr;
                        state    <= FILL_REQ;
                    end
                end
                FILL_REQ: if (mem_req_ready) begin
                    mem_req_valid <= 1'b0;
                    state         <= FILL_WAIT;
                end
                FILL_WAIT: if (mem_resp_valid) begin
                    valid[req_idx] <= 1'b1;
                    dirty[req_idx] <= 1'b0;
                    refill         <= 1'b1;
                    state          <= LOOKUP;
                end
                RESPOND: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Line storage carries no reset; valid bits alone decide what is present.
    always_ff @(posedge clk) begin
        if (state == LOOKUP && !req_clf && hit && req_we) lines[req_idx] <= merged;
        if (state == FILL_WAIT && mem_resp_valid) begin
            lines[req_idx] <= mem_rdata;
            tags[req_idx]  <= req_tag;
        end
    end
endmodule

// File: doc/l1_dcache_wb.md
# l1_dcache_wb

Parametrised, direct-mapped, write-back L1 data cache with valid/dirty tracking per line, miss handling against the next cache level, and cache-line flush. Sits between the CPU load/store port and the L2, replacing ad-hoc enable lines with valid/ready handshakes on both sides. Adds behaviour the previous L1 lacked: victim write-back, byte-sized store merge, a flush command, and saturating hit/miss counters.

## Interface
- ADDR_W, 64, address width
- DATA_W, 64, CPU data width (bits)
- LINE_W, 512, line width (bits); power of two, multiple of DATA_W
- SETS, 256, number of lines; power of two
- CNT_W, 32, hit/miss counter width
- Derived: OFFS_W=log2(LINE_W/8), IDX_W=log2(SETS), TAG_W=ADDR_W-IDX_W-OFFS_W
- clk in 1 rising-edge clock
- rst in 1 asynchronous, active-high reset
- cpu_req_valid in 1 request present
- cpu_req_ready out 1 cache accepts request
- cpu_we in 1 1=store, 0=load
- cpu_clf in 1 flush line at cpu_addr (overrides cpu_we)
- cpu_addr in ADDR_W byte address
- cpu_size in 2 access size 0=1B, 1=2B, 2=4B, 3=8B
- cpu_wdata in DATA_W store data, right-aligned
- cpu_resp_valid out 1 one-cycle response pulse
- cpu_rdata out DATA_W load data, zero-extended; 0 for stores/flush
- mem_req_valid out 1 request to L2
- mem_req_ready in 1 L2 accepts request
- mem_we out 1 1=line write-back, 0=line fill
- mem_addr out ADDR_W line-aligned address (low OFFS_W bits 0)
- mem_wdata out LINE_W victim line
- mem_resp_valid in 1 fill data valid (reads only)
- mem_rdata in LINE_W fill line
- hit_count, miss_count out CNT_W saturating counters

## Operation
- Address split: tag=addr[ADDR_W-1:IDX_W+OFFS_W], index=addr[IDX_W+OFFS_W-1:OFFS_W], offset=addr[OFFS_W-1:0]. Offset aligned down to size (low cpu_size bits cleared). Byte b of line = line[8b+7:8b].
- States: IDLE, LOOKUP, WRITEBACK, FILL_REQ, FILL_WAIT, RESPOND.
- IDLE: cpu_req_ready=1; request captured when valid&ready -> LOOKUP.
- LOOKUP: hit = valid[idx] & tag match. Load/store hit: read or merge bytes, store sets dirty, hit_count+1 -> RESPOND. Load/store miss: miss_count+1; dirty victim -> WRITEBACK, else FILL_REQ. Flush: dirty hit -> WRITEBACK; clean hit -> clear valid -> RESPOND; miss -> RESPOND. Flush does not count.
- WRITEBACK: mem_req_valid=1, mem_we=1, mem_addr={victim tag,idx,0}, mem_wdata=victim line; on mem_req_ready: clear dirty; flush -> clear valid -> RESPOND; else -> FILL_REQ.
- FILL_REQ: mem_req_valid=1, mem_we=0, mem_addr=request line address; on mem_req_ready -> FILL_WAIT.
- FILL_WAIT: on mem_resp_valid install mem_rdata, set tag, valid=1, dirty=0, then apply load/store as a hit (store sets dirty, no hit_count) -> RESPOND.
- RESPOND: cpu_resp_valid=1 one cycle -> IDLE. cpu_rdata held until next response.
- Counters saturate at 2^CNT_W-1.
- cpu_size above DATA_W/8 bytes is illegal; behaviour undefined.

## Timing
- Reset: state IDLE; all valid/dirty cleared; cpu_resp_valid=0, cpu_rdata=0, mem_req_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, counters=0; cpu_req_ready=0 while rst high.
- Hit latency: accepted at edge N, cpu_resp_valid high in cycle N+2, cpu_req_ready high again in cycle N+3.
- Clean miss: response 2 cycles after the mem_resp_valid edge.
- mem_req_valid, mem_we, mem_addr, mem_wdata stable until mem_req_ready; same-cycle ready completes handshake.
- mem_resp_valid outside FILL_WAIT ignored.
- Reset mid-transaction: transaction abandoned, mem_req_valid drops asynchronously, no response issued.

## Test plan
- Reset, load 0x1000 size 3, fill byte k=k -> mem read addr 0x1000, cpu_rdata=0x0706050403020100, miss_count=1; then load 0x1004 size 2 -> response cycle N+2, rdata=0x07060504, no mem request, hit_count=1.
- Store 0x1008 size 3 data 0xDEADBEEFCAFEF00D, then load 0x5000 (same index 0x40) -> write-back mem_we=1 addr 0x1000, bytes 8..15 = 0x0DF0FECAEFBEADDE order, then fill at 0x5000.
- Store 0x2003 size 0 data 0xAB after fill -> only byte 3 changes; load 0x2000 size 2 returns 0xAB020100 (fill byte k=k).
- Flush dirty 0x1000 -> one write-back, counters unchanged; next load 0x1000 misses; flush of absent line -> response, no mem traffic.
- mem_req_ready held 0 for 10 cycles -> mem request signals stable, cpu_req_ready=0, no response.
- Reset during FILL_WAIT -> outputs at reset values, later load to same address misses; CNT_W=4 with 20 hits -> hit_count=15.
